mem_access: RTL and testbench

Memory-access stage of the five-stage flowCPU_mips pipeline, between the EX/MEM register and the MEM/WB register. Non-memory instructions pass straight through to writeback. Loads and stores run a registered request/acknowledge transaction on the data bus, with byte-lane steering and sign or zero extension. While a transaction is outstanding the block raises `stallreq` so pipeline control holds the upstream stages.

---
 rtl/mem_access.sv | 185 ++++++++++++++++++
 tb/tb_mem_access.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access.sv
// Memory-access stage: passes non-memory ops to writeback, runs a registered
// req/ack bus transaction for loads/stores with big-endian lane steering.
module mem_access #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  mem_wd,
  input  logic        mem_wreg,
  input  logic [31:0] mem_wdata,
  input  logic        mem_enhilo,
  input  logic [31:0] mem_hi,
  input  logic [31:0] mem_lo,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_mem_addr,
  input  logic [31:0] mem_reg2,
  output logic [4:0]  wb_wd,
  output logic        wb_wreg,
  output logic [31:0] wb_wdata,
  output logic        wb_enhilo,
  output logic [31:0] wb_hi,
  output logic [31:0] wb_lo,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        stallreq,
  output logic        addr_err
);

  if (TIMEOUT != 0) begin : g_timeout_chk
    $error("mem_access: TIMEOUT is reserved and must be 0");
  end

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        bus_req_q, bus_we_q;
  logic [31:0] bus_addr_q, bus_wdata_q;
  logic [3:0]  bus_sel_q;

  logic        is_ld, is_st, sext, mem_op, misalign, start;
  size_e       sz;
  logic [3:0]  sel_d;
  logic [31:0] wdata_d, ld_ext;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sext  = 1'b0;
    sz    = SZ_W;
    case (mem_aluop)
      8'hE0: begin is_ld = 1'b1; sz = SZ_B; sext = 1'b1; end
      8'hE4: begin is_ld = 1'b1; sz = SZ_B; end
      8'hE1: begin is_ld = 1'b1; sz = SZ_H; sext = 1'b1; end
      8'hE5: begin is_ld = 1'b1; sz = SZ_H; end
      8'hE3: begin is_ld = 1'b1; sz = SZ_W; end
      8'hE8: begin is_st = 1'b1; sz = SZ_B; end
      8'hE9: begin is_st = 1'b1; sz = SZ_H; end
      8'hEB: begin is_st = 1'b1; sz = SZ_W; end
      default: ;
    endcase
    mem_op   = is_ld | is_st;
    misalign = ((sz == SZ_H) && mem_mem_addr[0]) ||
               ((sz == SZ_W) && (mem_mem_addr[1:0] != 2'b00));
    start    = mem_op && !misalign;
  end

  // Lane 3 (bits 31:24) holds the lowest byte address.
  always_comb begin
    sel_d   = 4'b1111;
    wdata_d = mem_reg2;
    case (sz)
      SZ_B: begin
        sel_d   = 4'b1000 >> mem_mem_addr[1:0];
        wdata_d = {4{mem_reg2[7:0]}};
      end
      SZ_H: begin
        sel_d   = mem_mem_addr[1] ? 4'b0011 : 4'b1100;
        wdata_d = {2{mem_reg2[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_ext = rdata_q;
    case (sz)
      SZ_B: begin
        logic [7:0] b;
        case (mem_mem_addr[1:0])
          2'b00:   b = rdata_q[31:24];
          2'b01:   b = rdata_q[23:16];
          2'b10:   b = rdata_q[15:8];
          default: b = rdata_q[7:0];
        endcase
        ld_ext = {{24{sext & b[7]}}, b};
      end
      SZ_H: begin
        logic [15:0] h;
        h      = mem_mem_addr[1] ? rdata_q[15:0] : rdata_q[31:16];
        ld_ext = {{16{sext & h[15]}}, h};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rdata_q     <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_sel_q   <= '0;
      bus_wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          bus_req_q   <= 1'b1;
          bus_we_q    <= is_st;
          bus_addr_q  <= {mem_mem_addr[31:2], 2'b00};
          bus_sel_q   <= sel_d;
          bus_wdata_q <= wdata_d;
          state_q     <= REQ;
        end
        REQ: if (bus_ack) begin
          rdata_q   <= bus_rdata;
          bus_req_q <= 1'b0;
          state_q   <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_sel   = bus_sel_q;
  assign bus_wdata = bus_wdata_q;

  // Writeback outputs are combinational pass-through, forced to zero while
  // reset is asserted so the MEM/WB register never sees stale data.
  always_comb begin
    wb_wd     = mem_wd;
    wb_wreg   = mem_wreg;
    wb_wdata  = mem_wdata;
    wb_enhilo = mem_enhilo;
    wb_hi     = mem_hi;
    wb_lo     = mem_lo;
    stallreq  = 1'b0;
    addr_err  = 1'b0;
    if (rst) begin
      wb_wd     = '0;
      wb_wreg   = 1'b0;
      wb_wdata  = '0;
      wb_enhilo = 1'b0;
      wb_hi     = '0;
      wb_lo     = '0;
    end else if (mem_op) begin
      if (misalign) begin
        addr_err = 1'b1;
        wb_wreg  = 1'b0;
      end else begin
        case (state_q)
          DONE: begin
            if (is_ld) wb_wdata = ld_ext;
            else       wb_wreg  = 1'b0;
          end
          default: begin
            stallreq = 1'b1;
            wb_wreg  = 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: directed loads/stores push expected bus
// requests and writeback results; a negedge monitor pops and compares them.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata;
  logic        mem_enhilo;
  logic [31:0] mem_hi, mem_lo;
  logic [7:0]  mem_aluop;
  logic [31:0] mem_mem_addr, mem_reg2;
  logic [4:0]  wb_wd;
  logic        wb_wreg;
  logic [31:0] wb_wdata;
  logic        wb_enhilo;
  logic [31:0] wb_hi, wb_lo;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_sel;
  logic [31:0] bus_rdata;
  logic        bus_ack;
  logic        stallreq, addr_err;

  mem_access #(.TIMEOUT(0)) dut (
    .clk(clk), .rst(rst),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
    .mem_enhilo(mem_enhilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
    .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2),
    .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
    .wb_enhilo(wb_enhilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_sel(bus_sel), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .stallreq(stallreq), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    logic        wreg;
    logic        chk_data;
    logic [31:0] wdata;
    int unsigned stall;
  } wb_exp_t;

  bus_exp_t    bus_q[$];
  wb_exp_t     wb_q[$];
  int unsigned rise_cyc[$];
  int          checks   = 0;
  int          failures = 0;
  int unsigned cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Monitor
  logic        prev_req = 1'b0, prev_stall = 1'b0;
  logic [3:0]  prev_sel = '0;
  int unsigned stall_cnt = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_req   = 1'b0;
      prev_stall = 1'b0;
      stall_cnt  = 0;
    end else begin
      if (bus_req && !prev_req) begin
        rise_cyc.push_back(cyc);
        if (bus_q.size() == 0) chk("unexpected_bus_req", 32'd1, 32'd0);
        else begin
          bus_exp_t e;
          e = bus_q.pop_front();
          chk("bus_we",    {31'd0, bus_we}, {31'd0, e.we});
          chk("bus_addr",  bus_addr, e.addr);
          chk("bus_sel",   {28'd0, bus_sel}, {28'd0, e.sel});
          chk("bus_wdata", bus_wdata, e.wdata);
        end
      end else if (bus_req && prev_req) begin
        chk("bus_sel_stable", {28'd0, bus_sel}, {28'd0, prev_sel});
      end
      if (stallreq) stall_cnt++;
      else if (prev_stall) begin
        if (wb_q.size() == 0) chk("unexpected_completion", 32'd1, 32'd0);
        else begin
          wb_exp_t w;
          w = wb_q.pop_front();
          chk("wb_wreg", {31'd0, wb_wreg}, {31'd0, w.wreg});
          if (w.chk_data) chk("wb_wdata", wb_wdata, w.wdata);
          chk("stall_cycles", stall_cnt, w.stall);
        end
        stall_cnt = 0;
      end
      prev_req   = bus_req;
      prev_sel   = bus_sel;
      prev_stall = stallreq;
    end
  end

  task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                         input logic [31:0] rdata, input int unsigned waits, input bit stray);
    bit seen;
    seen         = 1'b0;
    mem_aluop    = op;
    mem_mem_addr = addr;
    mem_reg2     = reg2;
    mem_wd       = 5'd7;
    mem_wreg     = 1'b1;
    mem_wdata    = 32'hDEAD_0000;
    mem_enhilo   = 1'b0;
    if (stray) begin
      bus_ack   = 1'b1;
      bus_rdata = 32'hBADB_AD00;
    end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (bus_req) begin seen = 1'b1; break; end
    end
    chk("req_seen", {31'd0, seen}, 32'd1);
    bus_ack = 1'b0;
    repeat (waits) begin @(posedge clk); #1; end
    bus_ack   = 1'b1;
    bus_rdata = rdata;
    @(posedge clk); #1;
    bus_ack   = 1'b0;
    bus_rdata = '0;
    @(posedge clk); #1;
    mem_aluop = 8'h00;
  endtask

  task automatic push(input logic we, input logic [31:0] a, input logic [3:0] s, input logic [31:0] wd,
                      input logic wr, input logic cd, input logic [31:0] wbd, input int unsigned st);
    bus_exp_t b;
    wb_exp_t  w;
    b = '{we: we, addr: a, sel: s, wdata: wd};
    w = '{wreg: wr, chk_data: cd, wdata: wbd, stall: st};
    bus_q.push_back(b);
    wb_q.push_back(w);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    mem_wd = 5'd9; mem_wreg = 1'b1; mem_wdata = 32'h5555_AAAA; mem_enhilo = 1'b1;
    mem_hi = 32'h1111_1111; mem_lo = 32'h2222_2222; mem_aluop = 8'h21;
    mem_mem_addr = '0; mem_reg2 = '0; bus_rdata = '0; bus_ack = 1'b0;
    #12;
    chk("rst_wb_wd",    {27'd0, wb_wd}, 32'd0);
    chk("rst_wb_wreg",  {31'd0, wb_wreg}, 32'd0);
    chk("rst_wb_wdata", wb_wdata, 32'd0);
    chk("rst_wb_hi",    wb_hi, 32'd0);
    chk("rst_bus_req",  {31'd0, bus_req}, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    chk("rst_stall",    {31'd0, stallreq}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Non-memory pass-through
    mem_aluop = 8'h21; mem_wd = 5'd3; mem_wreg = 1'b1; mem_wdata = 32'h0000_1234;
    mem_enhilo = 1'b1; mem_hi = 32'hCAFE_0001; mem_lo = 32'hCAFE_0002;
    #1;
    chk("nm_wb_wd",     {27'd0, wb_wd}, 32'd3);
    chk("nm_wb_wreg",   {31'd0, wb_wreg}, 32'd1);
    chk("nm_wb_wdata",  wb_wdata, 32'h0000_1234);
    chk("nm_wb_enhilo", {31'd0, wb_enhilo}, 32'd1);
    chk("nm_wb_hi",     wb_hi, 32'hCAFE_0001);
    chk("nm_wb_lo",     wb_lo, 32'hCAFE_0002);
    chk("nm_stall",     {31'd0, stallreq}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("nm_no_req", {31'd0, bus_req}, 32'd0);
    mem_enhilo = 1'b0;

    // Loads with one wait state
    push(1'b0, 32'h1000, 4'b0100, 32'h0, 1'b1, 1'b1, 32'hFFFF_FFF2, 3);
    run_mem(8'hE0, 32'h1001, 32'h0, 32'h11F2_3344, 1, 1'b0);
    push(1'b0, 32'h1000, 4'b0100, 32'h0, 1'b1, 1'b1, 32'h0000_00F2, 3);
    run_mem(8'hE4, 32'h1001, 32'h0, 32'h11F2_3344, 1, 1'b0);

    // Halfword loads, stores
    push(1'b0, 32'h5000, 4'b0011, 32'h0, 1'b1, 1'b1, 32'hFFFF_8001, 2);
    run_mem(8'hE1, 32'h5002, 32'h0, 32'h0000_8001, 0, 1'b0);
    push(1'b0, 32'h5000, 4'b1100, 32'h0, 1'b1, 1'b1, 32'h0000_8001, 2);
    run_mem(8'hE5, 32'h5000, 32'h0, 32'h8001_0000, 0, 1'b0);
    push(1'b1, 32'h2000, 4'b0011, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0, 2);
    run_mem(8'hE9, 32'h2002, 32'hAAAA_BEEF, 32'h0, 0, 1'b0);
    push(1'b1, 32'h6000, 4'b0001, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'h0, 2);
    run_mem(8'hE8, 32'h6003, 32'h1234_565A, 32'h0, 0, 1'b0);

    // Misaligned word load
    mem_aluop = 8'hE3; mem_mem_addr = 32'h3002; mem_wreg = 1'b1;
    #1;
    chk("mis_addr_err", {31'd0, addr_err}, 32'd1);
    chk("mis_stall",    {31'd0, stallreq}, 32'd0);
    chk("mis_wb_wreg",  {31'd0, wb_wreg}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("mis_no_req", {31'd0, bus_req}, 32'd0);
    mem_aluop = 8'h00;
    #1;
    chk("nm_addr_err", {31'd0, addr_err}, 32'd0);
    @(posedge clk); #1;

    // Back-to-back SW then LW, stray ack in the LW's IDLE cycle
    push(1'b1, 32'h4000, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0, 2);
    push(1'b0, 32'h4000, 4'b1111, 32'h0, 1'b1, 1'b1, 32'h1234_5678, 2);
    run_mem(8'hEB, 32'h4000, 32'hCAFE_F00D, 32'h0, 0, 1'b0);
    run_mem(8'hE3, 32'h4000, 32'h0, 32'h1234_5678, 0, 1'b1);
    if (rise_cyc.size() >= 2)
      chk("b2b_spacing", rise_cyc[rise_cyc.size()-1] - rise_cyc[rise_cyc.size()-2], 32'd3);
    else
      chk("b2b_rises", rise_cyc.size(), 32'd2);

    // Reset while a LW waits in REQ
    bus_q.push_back('{we: 1'b0, addr: 32'h100, sel: 4'b1111, wdata: 32'h0});
    mem_aluop = 8'hE3; mem_mem_addr = 32'h100; mem_reg2 = '0;
    mem_wd = 5'd5; mem_wreg = 1'b1; mem_wdata = 32'h7777_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_req", {31'd0, bus_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_req",   {31'd0, bus_req}, 32'd0);
    chk("mid_rst_stall", {31'd0, stallreq}, 32'd0);
    chk("mid_rst_wd",    {27'd0, wb_wd}, 32'd0);
    chk("mid_rst_wdata", wb_wdata, 32'd0);
    @(negedge clk);
    mem_aluop = 8'h00;
    #2 rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_req",   {31'd0, bus_req}, 32'd0);
    chk("post_rst_stall", {31'd0, stallreq}, 32'd0);
    mem_aluop = 8'hE3;
    #1;
    chk("post_rst_idle_stall", {31'd0, stallreq}, 32'd1);
    mem_aluop = 8'h00;
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;

    chk("bus_q_empty", bus_q.size(), 32'd0);
    chk("wb_q_empty",  wb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
